// File: rtl/raycaster_pkg.sv
// Shared types and default dimensions for the raycaster pipeline stages
// (column scheduler, DDA, transformation).
package raycaster_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int HCOUNT_W         = 11;
    localparam int DEF_SCREEN_WIDTH = 320;
    localparam int DEF_CREDITS      = 8;
    localparam int DEF_POS_W        = 16;

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter that starts full, saturates at both ends and
// raises a sticky error when a credit is returned while already full.
module credit_counter #(
    parameter int CREDITS = 8,
    parameter int CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             take_i,
    input  logic             give_i,
    output logic [CNT_W-1:0] count_o,
    output logic             err_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);

    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // A take and a give in the same cycle cancel out, even when full.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (take_i && !give_i) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end else if (give_i && !take_i) begin
            if (count_q == FULL) err_d = 1'b1;
            else                 count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= FULL;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/ray_column_scheduler.sv
// Issues one ray request per screen column to the DDA, throttled by credits
// for the DDA output FIFO, and signals frame end once every ray has retired.
module ray_column_scheduler
    import raycaster_pkg::*;
#(
    parameter int SCREEN_WIDTH = DEF_SCREEN_WIDTH,
    parameter int CREDITS      = DEF_CREDITS,
    parameter int POS_W        = DEF_POS_W
) (
    input  logic                clk_in,
    input  logic                rst_in_n,
    input  logic                frame_start_in,
    input  logic [POS_W-1:0]    pos_x_in,
    input  logic [POS_W-1:0]    pos_y_in,
    input  logic [POS_W-1:0]    dir_x_in,
    input  logic [POS_W-1:0]    dir_y_in,
    input  logic                dda_ready_in,
    input  logic                ray_done_in,
    input  logic                credit_return_in,
    output logic                ray_valid_out,
    output logic [HCOUNT_W-1:0] hcount_ray_out,
    output logic [POS_W-1:0]    pos_x_out,
    output logic [POS_W-1:0]    pos_y_out,
    output logic [POS_W-1:0]    dir_x_out,
    output logic [POS_W-1:0]    dir_y_out,
    output logic                busy_out,
    output logic                frame_done_out,
    output logic                overrun_out,
    output logic                credit_err_out,
    output sched_state_t        state_dbg_out
);

    localparam int                 CNT_W       = $clog2(CREDITS + 1);
    localparam int                 RET_W       = HCOUNT_W + 1;
    localparam logic [HCOUNT_W-1:0] LAST_COL    = HCOUNT_W'(SCREEN_WIDTH - 1);
    localparam logic [RET_W-1:0]    ALL_RETIRED = RET_W'(SCREEN_WIDTH);

    sched_state_t        state_q, state_d;
    logic [HCOUNT_W-1:0] column_q, column_d;
    logic [RET_W-1:0]    retired_q, retired_d;
    logic [POS_W-1:0]    pos_x_q, pos_y_q, dir_x_q, dir_y_q;
    logic                overrun_q;
    logic [CNT_W-1:0]    credit_count;
    logic                transfer;
    logic                start_accept;
    logic                retire_en;

    // Handshake: a ray transfers on any cycle where ray_valid_out and
    // dda_ready_in are both high; hcount_ray_out holds until that cycle.
    assign transfer     = ray_valid_out && dda_ready_in;
    assign start_accept = (state_q == IDLE) && frame_start_in;
    assign retire_en    = ray_done_in && ((state_q == ISSUE) || (state_q == DRAIN));

    credit_counter #(
        .CREDITS (CREDITS),
        .CNT_W   (CNT_W)
    ) u_credits (
        .clk_i   (clk_in),
        .rst_ni  (rst_in_n),
        .take_i  (transfer),
        .give_i  (credit_return_in),
        .count_o (credit_count),
        .err_o   (credit_err_out)
    );

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // DRAIN looks at the post-increment retire count so the last ray_done_in
    // moves to DONE on the very next edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (frame_start_in) state_d = ISSUE;
            ISSUE:   if (transfer && (column_q == LAST_COL)) state_d = DRAIN;
            DRAIN:   if (retired_d == ALL_RETIRED) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ray_valid_out  = (state_q == ISSUE) && (credit_count != '0);
        busy_out       = (state_q != IDLE);
        frame_done_out = (state_q == DONE);
        state_dbg_out  = state_q;
    end

    always_comb begin
        column_d  = column_q;
        retired_d = retired_q;
        if (start_accept) begin
            column_d  = '0;
            retired_d = '0;
        end else begin
            if (transfer)  column_d  = column_q + 1'b1;
            if (retire_en) retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            column_q  <= '0;
            retired_q <= '0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            dir_x_q   <= '0;
            dir_y_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            column_q  <= column_d;
            retired_q <= retired_d;
            overrun_q <= frame_start_in && (state_q != IDLE);
            if (start_accept) begin
                pos_x_q <= pos_x_in;
                pos_y_q <= pos_y_in;
                dir_x_q <= dir_x_in;
                dir_y_q <= dir_y_in;
            end
        end
    end

    assign hcount_ray_out = column_q;
    assign pos_x_out      = pos_x_q;
    assign pos_y_out      = pos_y_q;
    assign dir_x_out      = dir_x_q;
    assign dir_y_out      = dir_y_q;
    assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Randomised bench for ray_column_scheduler with a count-based reference
// model, a column scoreboard and a small DDA / FIFO-pop responder.
module tb_ray_column_scheduler;
    import raycaster_pkg::*;

    localparam int SW = 8;
    localparam int CR = 2;
    localparam int PW = 16;

    logic                clk = 1'b0;
    logic                rst_in_n;
    logic                frame_start_in;
    logic [PW-1:0]       pos_x_in, pos_y_in, dir_x_in, dir_y_in;
    logic                dda_ready_in, ray_done_in, credit_return_in;
    logic                ray_valid_out;
    logic [HCOUNT_W-1:0] hcount_ray_out;
    logic [PW-1:0]       pos_x_out, pos_y_out, dir_x_out, dir_y_out;
    logic                busy_out, frame_done_out, overrun_out, credit_err_out;
    sched_state_t        state_dbg_out;

    always #5 clk = ~clk;

    ray_column_scheduler #(.SCREEN_WIDTH(SW), .CREDITS(CR), .POS_W(PW)) dut (
        .clk_in           (clk),
        .rst_in_n         (rst_in_n),
        .frame_start_in   (frame_start_in),
        .pos_x_in         (pos_x_in),
        .pos_y_in         (pos_y_in),
        .dir_x_in         (dir_x_in),
        .dir_y_in         (dir_y_in),
        .dda_ready_in     (dda_ready_in),
        .ray_done_in      (ray_done_in),
        .credit_return_in (credit_return_in),
        .ray_valid_out    (ray_valid_out),
        .hcount_ray_out   (hcount_ray_out),
        .pos_x_out        (pos_x_out),
        .pos_y_out        (pos_y_out),
        .dir_x_out        (dir_x_out),
        .dir_y_out        (dir_y_out),
        .busy_out         (busy_out),
        .frame_done_out   (frame_done_out),
        .overrun_out      (overrun_out),
        .credit_err_out   (credit_err_out),
        .state_dbg_out    (state_dbg_out)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: frame progress as plain counts.
    bit            m_busy, m_done_now, m_overrun, m_err;
    int            m_col, m_ret, m_cred;
    logic [PW-1:0] m_px, m_py, m_dx, m_dy;
    logic [HCOUNT_W-1:0] exp_q[$];

    // DDA responder state.
    int done_q[$];
    int last_due;
    int pend_ret;
    bit auto_ret;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done_now = 0; m_overrun = 0; m_err = 0;
        m_col = 0; m_ret = 0; m_cred = CR;
        m_px = '0; m_py = '0; m_dx = '0; m_dy = '0;
        exp_q.delete();
        done_q.delete();
        last_due = 0;
        pend_ret = 0;
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = m_busy && !m_done_now && (m_col < SW) && (m_cred > 0);
        check("ray_valid", ray_valid_out, exp_valid);
        check("hcount", hcount_ray_out, m_col);
        check("busy", busy_out, m_busy);
        check("frame_done", frame_done_out, m_done_now);
        check("overrun", overrun_out, m_overrun);
        check("credit_err", credit_err_out, m_err);
        check("state_idle", state_dbg_out == IDLE, !m_busy);
        check("pos_x", pos_x_out, m_px);
        check("pos_y", pos_y_out, m_py);
        check("dir_x", dir_x_out, m_dx);
        check("dir_y", dir_y_out, m_dy);
    endtask

    task automatic tick(input bit fs, input bit rdy, input bit cret_extra);
        bit exp_valid, xfer, cret, dn, auto_part, drain;
        int due;
        frame_start_in = fs;
        dda_ready_in   = rdy;
        dn             = (done_q.size() > 0) && (done_q[0] <= cyc);
        ray_done_in    = dn;
        auto_part      = auto_ret && (pend_ret > 0) && ($urandom_range(0, 3) != 0);
        cret           = cret_extra || auto_part;
        credit_return_in = cret;
        @(negedge clk);
        check_outputs();
        exp_valid = m_busy && !m_done_now && (m_col < SW) && (m_cred > 0);
        if (ray_valid_out && dda_ready_in) begin
            if (exp_q.size() == 0) check("xfer_unexpected", 1, 0);
            else                   check("xfer_col", hcount_ray_out, exp_q.pop_front());
            due = cyc + $urandom_range(1, 4);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            done_q.push_back(due);
        end
        if (dn) begin
            void'(done_q.pop_front());
            pend_ret++;
        end
        if (auto_part) pend_ret--;
        if (frame_done_out) check("frame_cols_left", exp_q.size(), 0);

        xfer = exp_valid && rdy;
        if (xfer && !cret) m_cred--;
        else if (cret && !xfer) begin
            if (m_cred == CR) m_err = 1;
            else              m_cred++;
        end
        m_overrun = fs && m_busy;
        if (!m_busy) begin
            if (fs) begin
                m_busy = 1; m_col = 0; m_ret = 0;
                m_px = pos_x_in; m_py = pos_y_in; m_dx = dir_x_in; m_dy = dir_y_in;
                exp_q.delete();
                for (int i = 0; i < SW; i++) exp_q.push_back(HCOUNT_W'(i));
            end
        end else if (m_done_now) begin
            m_busy = 0;
            m_done_now = 0;
        end else begin
            drain = (m_col == SW);
            m_ret = m_ret + int'(dn);
            if (drain && m_ret == SW) m_done_now = 1;
            if (xfer) m_col++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic mid_reset();
        #2;
        frame_start_in = 0; dda_ready_in = 0; ray_done_in = 0; credit_return_in = 0;
        rst_in_n = 0;
        #1;
        check("rst_valid", ray_valid_out, 0);
        check("rst_hcount", hcount_ray_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", frame_done_out, 0);
        check("rst_overrun", overrun_out, 0);
        check("rst_credit_err", credit_err_out, 0);
        check("rst_pos_x", pos_x_out, 0);
        check("rst_pos_y", pos_y_out, 0);
        check("rst_dir_x", dir_x_out, 0);
        check("rst_dir_y", dir_y_out, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_in_n = 1;
        cyc++;
    endtask

    task automatic randomize_cfg();
        pos_x_in = PW'($urandom);
        pos_y_in = PW'($urandom);
        dir_x_in = PW'($urandom);
        dir_y_in = PW'($urandom);
    endtask

    // rdy_mode: 0 always ready, 1 toggling, 2 random.
    task automatic run_frame(input int rdy_mode, input int ovr_at, input int rst_col);
        bit rdy, fs;
        randomize_cfg();
        tick(1, 1, 0);
        for (int n = 0; n < 400; n++) begin
            if (!m_busy) break;
            if (rst_col >= 0 && hcount_ray_out == HCOUNT_W'(rst_col)) begin
                mid_reset();
                return;
            end
            randomize_cfg();
            if (n == ovr_at) pos_x_in = 16'h1234;
            case (rdy_mode)
                0:       rdy = 1;
                1:       rdy = (n % 2 == 0);
                default: rdy = ($urandom_range(0, 1) == 1);
            endcase
            fs = (n == ovr_at) || (rdy_mode == 2 && $urandom_range(0, 29) == 0);
            tick(fs, rdy, 0);
        end
        if (m_busy) check("frame_timeout", 1, 0);
    endtask

    task automatic drain_returns();
        for (int n = 0; n < 100; n++) begin
            if (pend_ret == 0 && done_q.size() == 0) break;
            tick(0, 0, 0);
        end
        check("drain_timeout", pend_ret + done_q.size(), 0);
    endtask

    initial begin
        rst_in_n = 0;
        frame_start_in = 0; dda_ready_in = 0; ray_done_in = 0; credit_return_in = 0;
        pos_x_in = '0; pos_y_in = '0; dir_x_in = '0; dir_y_in = '0;
        auto_ret = 0;
        model_reset();
        mid_reset();

        // No credit returns: two rays issue, then a stall on column 2.
        randomize_cfg();
        tick(1, 1, 0);
        repeat (5) tick(0, 1, 0);
        check("stall_hcount", hcount_ray_out, 2);
        check("stall_valid", ray_valid_out, 0);
        mid_reset();

        auto_ret = 1;
        run_frame(0, -1, -1); drain_returns();
        run_frame(1, -1, -1); drain_returns();
        run_frame(0, 3, -1);  drain_returns();
        repeat (4) begin
            run_frame(2, -1, -1); drain_returns();
        end

        // Spurious return while full: sticky error across a whole frame.
        tick(0, 0, 1);
        repeat (3) tick(0, 0, 0);
        run_frame(2, -1, -1); drain_returns();
        check("err_sticky", credit_err_out, 1);

        // Asynchronous reset in the middle of column 5.
        run_frame(0, -1, 5);
        repeat (2) tick(0, 0, 0);
        run_frame(2, -1, -1); drain_returns();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
